// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM encoding and default word width for the serializer.
package seq_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/seq_serializer_if.sv
// seq_serializer_if: word input handshake plus serial bit-stream output.
interface seq_serializer_if #(parameter int WIDTH = seq_pkg::DEFAULT_WIDTH);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic out_en;
  logic x;
  logic x_valid;
  logic busy;
  modport master(output in_data, in_valid, out_en, input in_ready, x, x_valid, busy);
  modport slave(input in_data, in_valid, out_en, output in_ready, x, x_valid, busy);
endinterface

// File: rtl/seq_fifo2.sv
// seq_fifo2: 2-entry in-order word buffer; push when full and pop when empty are ignored.
module seq_fifo2 import seq_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [2];
  logic rd_q, wr_q;
  logic [1:0] cnt_q;
  logic do_push, do_pop;
  assign full    = cnt_q == 2'd2;
  assign empty   = cnt_q == 2'd0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_q];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/seq_serializer.sv
// seq_serializer: buffers parallel words and shifts them out one bit per out_en strobe.
module seq_serializer import seq_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic            clk,
  input logic            reset,
  seq_serializer_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q;
  logic [WIDTH-1:0] sh_q, head;
  logic [CW-1:0] cnt_q;
  logic full, empty, pop, last_bit, shifting;
  assign shifting = state_q == SHIFT;
  assign last_bit = shifting && s.out_en && cnt_q == '0;
  // Loading from IDLE ignores out_en; reload on the last bit keeps words gap-free.
  assign pop = !empty && (!shifting || last_bit);
  seq_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (s.in_valid & ~full),
    .pop  (pop),
    .din  (s.in_data),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else if (pop) begin
      state_q <= SHIFT;
      sh_q    <= head;
      cnt_q   <= LAST;
    end else if (last_bit) begin
      state_q <= IDLE;
      sh_q    <= '0;
    end else if (shifting && s.out_en) begin
      sh_q  <= MSB_FIRST ? sh_q << 1 : sh_q >> 1;
      cnt_q <= cnt_q - CW'(1);
    end
  end
  assign s.in_ready = ~full;
  assign s.x_valid  = shifting;
  assign s.x        = shifting & (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]);
  assign s.busy     = shifting | ~empty;
endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: directed checks of MSB-first and LSB-first serializer instances.
module tb_seq_serializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_bad = 0;
  seq_serializer_if #(.WIDTH(8)) m_if ();
  seq_serializer_if #(.WIDTH(8)) l_if ();
  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .s(m_if));
  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .s(l_if));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // seq[7] is the first bit expected on x
  task automatic send_word(input bit lsb, input logic [7:0] w, input logic [7:0] seq);
    if (lsb) begin l_if.in_data = w; l_if.in_valid = 1'b1; end
    else begin m_if.in_data = w; m_if.in_valid = 1'b1; end
    step();
    m_if.in_valid = 1'b0;
    l_if.in_valid = 1'b0;
    chk("lat_xv", lsb ? l_if.x_valid : m_if.x_valid, 0);
    chk("lat_busy", lsb ? l_if.busy : m_if.busy, 1);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("bit", lsb ? l_if.x : m_if.x, seq[7-i]);
      chk("bit_xv", lsb ? l_if.x_valid : m_if.x_valid, 1);
      step();
    end
    chk("end_xv", lsb ? l_if.x_valid : m_if.x_valid, 0);
    chk("end_busy", lsb ? l_if.busy : m_if.busy, 0);
  endtask

  initial begin
    logic [23:0] s2;
    logic [7:0] pa;
    logic [7:0] wd [4];
    logic [31:0] rx;
    int k, nrx;
    bit acc, rxb, rxv;
    m_if.in_data = '0; m_if.in_valid = 1'b0; m_if.out_en = 1'b1;
    l_if.in_data = '0; l_if.in_valid = 1'b0; l_if.out_en = 1'b1;
    #2;
    chk("rst_x", m_if.x, 0);
    chk("rst_xv", m_if.x_valid, 0);
    chk("rst_busy", m_if.busy, 0);
    chk("rst_rdy", m_if.in_ready, 1);
    step();
    step();
    reset = 1'b0;
    step();
    send_word(1'b0, 8'hE0, 8'hE0);
    // three words back to back: 24 contiguous bits
    s2 = 24'hE781FF;
    m_if.in_data = 8'hE7; m_if.in_valid = 1'b1;
    step();
    chk("t2_rdy1", m_if.in_ready, 1);
    chk("t2_xv0", m_if.x_valid, 0);
    m_if.in_data = 8'h81;
    step();
    for (int i = 0; i < 24; i++) begin
      if (i == 0) m_if.in_data = 8'hFF;
      if (i == 1) begin
        chk("t2_full", m_if.in_ready, 0);
        m_if.in_valid = 1'b0;
      end
      if (i == 8) chk("t2_free", m_if.in_ready, 1);
      chk("t2_bit", m_if.x, s2[23-i]);
      chk("t2_xv", m_if.x_valid, 1);
      step();
    end
    chk("t2_end_xv", m_if.x_valid, 0);
    chk("t2_end_busy", m_if.busy, 0);
    chk("t2_end_rdy", m_if.in_ready, 1);
    // out_en strobing every other cycle
    pa = 8'hA5;
    m_if.in_data = pa; m_if.in_valid = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    step();
    for (int j = 0; j < 16; j++) begin
      chk("t3_bit", m_if.x, pa[7-j/2]);
      chk("t3_xv", m_if.x_valid, 1);
      m_if.out_en = (j % 2) == 1;
      step();
    end
    chk("t3_end_xv", m_if.x_valid, 0);
    m_if.out_en = 1'b1;
    send_word(1'b1, 8'h01, 8'h80);
    // reset mid-word with one word queued
    m_if.in_data = 8'hFF; m_if.in_valid = 1'b1;
    step();
    m_if.in_data = 8'h3C;
    step();
    m_if.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_bit", m_if.x, 1);
      if (i < 2) step();
    end
    reset = 1'b1;
    #1;
    chk("t5_x", m_if.x, 0);
    chk("t5_xv", m_if.x_valid, 0);
    chk("t5_busy", m_if.busy, 0);
    chk("t5_rdy", m_if.in_ready, 1);
    step();
    reset = 1'b0;
    step();
    chk("t5_idle", m_if.busy, 0);
    send_word(1'b0, 8'h0F, 8'h0F);
    // in_valid held against a full FIFO while out_en stalls
    wd = '{8'h11, 8'h22, 8'h33, 8'h44};
    k = 0; nrx = 0; rx = '0;
    m_if.out_en = 1'b0;
    for (int c = 0; c < 80 && nrx < 32; c++) begin
      if (c == 6) begin
        chk("t6_stall_rdy", m_if.in_ready, 0);
        chk("t6_stall_k", k, 3);
        m_if.out_en = 1'b1;
      end
      m_if.in_valid = k < 4;
      m_if.in_data = wd[k < 4 ? k : 3];
      acc = m_if.in_valid && m_if.in_ready;
      rxb = m_if.x_valid && m_if.out_en;
      rxv = m_if.x;
      step();
      if (acc) k++;
      if (rxb) begin
        rx = {rx[30:0], rxv};
        nrx++;
      end
    end
    m_if.in_valid = 1'b0;
    chk("t6_nrx", nrx, 32);
    chk("t6_order", rx, 32'h11223344);
    chk("t6_k", k, 4);
    chk("t6_busy", m_if.busy, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
